// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background SECDED scrubber sharing a RAM port with the host
// Walks every codeword, rewrites single-bit errors corrected, reports and counts double errors.
module ecc_scrub_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic [38:0]       mem_rdata,
  output logic [31:0]       dec_din,
  output logic [6:0]        dec_ecc_in,
  input  logic [31:0]       dec_dout,
  input  logic [6:0]        dec_ecc_out,
  input  logic              dec_single,
  input  logic              dec_double,
  output logic              busy,
  output logic              done,
  output logic              err_valid,
  output logic              err_uncorr,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INT,
    S_RD_REQ,
    S_RD_DATA,
    S_CHECK,
    S_WR_REQ,
    S_NEXT
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]       INTERVAL_L = 16'(INTERVAL);
  localparam logic [15:0]       CNT_MAX    = 16'hFFFF;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wait_q, wait_d;
  logic [38:0]         cap_q, cap_d;
  logic [38:0]         wr_q, wr_d;
  logic                done_q, done_d;
  logic                err_valid_q, err_valid_d;
  logic                err_uncorr_q, err_uncorr_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [15:0]         corr_q, corr_d;
  logic [15:0]         uncorr_q, uncorr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wait_q       <= '0;
      cap_q        <= '0;
      wr_q         <= '0;
      done_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_uncorr_q <= 1'b0;
      err_addr_q   <= '0;
      corr_q       <= '0;
      uncorr_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wait_q       <= wait_d;
      cap_q        <= cap_d;
      wr_q         <= wr_d;
      done_q       <= done_d;
      err_valid_q  <= err_valid_d;
      err_uncorr_q <= err_uncorr_d;
      err_addr_q   <= err_addr_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wait_d       = wait_q;
    cap_d        = cap_q;
    wr_d         = wr_q;
    done_d       = 1'b0;
    err_valid_d  = 1'b0;
    err_uncorr_d = err_uncorr_q;
    err_addr_d   = err_addr_q;
    corr_d       = corr_q;
    uncorr_d     = uncorr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = '0;
          corr_d   = '0;
          uncorr_d = '0;
          wait_d   = INTERVAL_L;
          state_d  = S_WAIT_INT;
        end
      end
      S_WAIT_INT: begin
        if (wait_q <= 16'd1) begin
          state_d = S_RD_REQ;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      S_RD_REQ: begin
        if (mem_gnt) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        cap_d   = mem_rdata;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // a double error may also raise single; it must never be written back
        if (dec_double) begin
          if (uncorr_q != CNT_MAX) uncorr_d = uncorr_q + 16'd1;
          err_valid_d  = 1'b1;
          err_uncorr_d = 1'b1;
          err_addr_d   = addr_q;
          state_d      = S_NEXT;
        end else if (dec_single) begin
          if (corr_q != CNT_MAX) corr_d = corr_q + 16'd1;
          err_valid_d  = 1'b1;
          err_uncorr_d = 1'b0;
          err_addr_d   = addr_q;
          wr_d         = {dec_ecc_out, dec_dout};
          state_d      = S_WR_REQ;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_REQ: begin
        if (mem_gnt) state_d = S_NEXT;
      end
      S_NEXT: begin
        wait_d = INTERVAL_L;
        if (addr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = continuous ? S_WAIT_INT : S_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_WAIT_INT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // address and write data are registers untouched while a request is pending
  assign mem_req    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign mem_we     = (state_q == S_WR_REQ);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wr_q;
  assign dec_din    = cap_q[31:0];
  assign dec_ecc_in = cap_q[38:32];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err_valid  = err_valid_q;
  assign err_uncorr = err_uncorr_q;
  assign err_addr   = err_addr_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;

endmodule

// File: doc/ecc_scrub_ctrl.md
# ecc_scrub_ctrl

Background memory scrubber for the SECDED-protected (39,32) storage path. It walks every word of an external codeword RAM and runs each word through the external `rvecc_decode` instance. Single-bit errors are written back corrected; double-bit errors are counted and reported but not written. It shares the RAM port with the host through a request/grant handshake in which the host always wins. At top level it sits between the RAM arbiter and a dedicated decoder instance.

## Interface

Parameters:
- ADDR_W, 8, RAM address width; scrub range is 0 .. 2**ADDR_W-1
- INTERVAL, 16, idle cycles inserted before each word's read request (legal range 1..65535)

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; honoured only in IDLE
- continuous  in  1  sampled at end of pass; 1 = start next pass automatically
- mem_req  out  1  RAM access request
- mem_gnt  in  1  RAM grant; access occurs in any cycle with mem_req && mem_gnt
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  access address; valid while mem_req
- mem_wdata  out  39  {ecc[6:0], data[31:0]}; valid while mem_req && mem_we
- mem_rdata  in  39  read codeword, valid the cycle after a granted read
- dec_din  out  32  to decoder din (captured data)
- dec_ecc_in  out  7  to decoder ecc_in (captured ecc)
- dec_dout  in  32  decoder corrected data
- dec_ecc_out  in  7  decoder corrected ecc
- dec_single  in  1  decoder single_ecc_error
- dec_double  in  1  decoder double_ecc_error
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion of a pass
- err_valid  out  1  one-cycle pulse when a word with an error is found
- err_uncorr  out  1  qualifies err_valid: 1 = double error
- err_addr  out  ADDR_W  address of the reported error; held until next err_valid
- corr_cnt  out  16  saturating count of corrected words
- uncorr_cnt  out  16  saturating count of uncorrectable words

## Operation

- Top level ties decoder en = 1. The decoder is combinational on dec_din/dec_ecc_in, which are driven from a 39-bit capture register.
- FSM states are IDLE, WAIT_INT, RD_REQ, RD_DATA, CHECK, WR_REQ, NEXT.
- IDLE: when start=1, set addr←0 and clear corr_cnt/uncorr_cnt, then go to WAIT_INT. start in any other state is ignored.
- WAIT_INT: down-counter loaded with INTERVAL on entry; when it reaches 1, go to RD_REQ.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=addr. Hold until mem_gnt=1, then go to RD_DATA.
- RD_DATA: capture mem_rdata into the capture register, then go to CHECK.
- CHECK, priority order:
  - dec_double=1 (including dec_single=1 at the same time): uncorr_cnt++, err_valid=1, err_uncorr=1, err_addr=addr; go to NEXT with no write.
  - dec_single=1 only: corr_cnt++, err_valid=1, err_uncorr=0, err_addr=addr, latch {dec_ecc_out, dec_dout} into the write register; go to WR_REQ.
  - Otherwise go to NEXT.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=write register. Hold until mem_gnt=1, then go to NEXT.
- NEXT, not at the last address: addr++, go to WAIT_INT.
- NEXT, at addr = 2**ADDR_W-1:
  - Pulse done and set addr←0.
  - If continuous=1, go to WAIT_INT; counters are not cleared.
  - Otherwise go to IDLE.
- Counters stick at 16'hFFFF and do not wrap.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req is high.

## Timing

- Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, capture register=0, busy=0, done=0, err_valid=0, err_uncorr=0, err_addr=0, corr_cnt=0, uncorr_cnt=0.
- rst asserted mid-pass (including with mem_req high) aborts the pass on the next edge. No write is issued afterwards.
- start accepted on edge N: busy=1 from cycle N+1.
- Per word with mem_gnt tied high:
  - Clean word: INTERVAL + 4 cycles (WAIT_INT×INTERVAL, RD_REQ, RD_DATA, CHECK, NEXT).
  - Corrected word: INTERVAL + 5 cycles.
- Each cycle of mem_gnt=0 in RD_REQ or WR_REQ adds one cycle.
- err_valid and the counter update are registered: visible the cycle after CHECK.
- done is visible the cycle after NEXT at the last address.
- On a one-shot pass, busy falls in the same cycle done is high.

## Test plan

- ADDR_W=2, INTERVAL=1, all four RAM words valid codewords, mem_gnt=1, one start pulse → no writes, done after 20 cycles, counters 0/0, busy low afterwards.
- Word 2 has data bit 5 flipped → exactly one write, to addr 2, containing the original codeword; err_valid with err_uncorr=0 and err_addr=2; corr_cnt=1.
- Word 1 has bits 0 and 33 flipped → no write; err_valid with err_uncorr=1 and err_addr=1; uncorr_cnt=1; the RAM word is unchanged.
- mem_gnt held low for 7 cycles during both RD_REQ and WR_REQ → mem_req, mem_addr, mem_we and mem_wdata stay stable; the access completes on the first grant; the pass takes 14 extra cycles.
- continuous=1 with one single-error word → second pass finds no errors; done pulses twice; corr_cnt stays 1; start pulses while busy are ignored.
- rst asserted in the cycle WR_REQ is waiting with mem_gnt=0 → next cycle mem_req=0, state IDLE, all outputs at reset values, no RAM write.
